// File: rtl/ir_pkg.sv
// Shared definitions for the 16-bit CPU instruction path.
// Holds the default instruction width, instruction field positions and the
// instruction word type used by fetch, the instruction queue and the decoder.
package ir_pkg;

  localparam int unsigned DATA_W = 16;

  // Instruction field positions
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_MSB = 7;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_MSB = 3;
  localparam int unsigned RS2_LSB = 0;

  typedef logic [DATA_W-1:0] instr_t;

  // Extract the opcode field of an instruction word
  function automatic logic [OPC_MSB-OPC_LSB:0] get_opcode(input instr_t ins);
    return ins[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/ir_queue_mem.sv
// Storage array for ir_queue: DEPTH x DATA_W registers, synchronous write,
// asynchronous read. Contents are never reset.
// Ports:
//   Clock    - rising-edge clock
//   i_we     - write enable
//   i_waddr  - write index
//   i_wdata  - write data
//   i_raddr  - read index
//   o_rdata  - read data (combinational from i_raddr)
module ir_queue_mem #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge Clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ir_queue.sv
// Instruction register queue between instruction fetch and decode.
// Buffers up to DEPTH words in program order, presents the oldest one under a
// Valid/Rd handshake, and drops everything on Flush (branch/jump) or Reset.
// Optional feature macro: IR_QUEUE_BYPASS_EN -- when defined, a word loaded
// into an empty queue falls through to instructionOut in the same cycle.
// Ports:
//   Clock, Reset    - rising-edge clock, synchronous active-high reset
//   Ld, instruction - push request and word; accepted when LdReady
//   LdReady         - queue not full
//   Rd              - decoder accepts head word; pops when Valid
//   Flush           - discard all entries at this edge
//   instructionOut  - head word, 0 when !Valid
//   Valid, Full     - head valid / Count == DEPTH
//   Count           - number of stored entries
module ir_queue #(
  parameter int unsigned DATA_W = ir_pkg::DATA_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Ld,
  input  logic [DATA_W-1:0]          instruction,
  output logic                       LdReady,
  input  logic                       Rd,
  input  logic                       Flush,
  output logic [DATA_W-1:0]          instructionOut,
  output logic                       Valid,
  output logic                       Full,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  import ir_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_rd_data;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

  // A full queue rejects a push even if a pop frees a slot in the same cycle
  assign w_push  = Ld && !w_full;

`ifdef IR_QUEUE_BYPASS_EN
  // Empty queue: the incoming word is presented immediately; if it is also
  // popped, push and pop cancel and Count stays 0.
  assign w_valid = !w_empty || (Ld && !Flush);
  assign w_head  = w_empty ? instruction : w_rd_data;
`else
  assign w_valid = !w_empty;
  assign w_head  = w_rd_data;
`endif

  assign w_pop   = Rd && w_valid;

  ir_queue_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .Clock   (Clock),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (instruction),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  // Pointer and occupancy state; Reset and Flush both empty the queue
  always_ff @(posedge Clock) begin
    if (Reset || Flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign LdReady        = !w_full;
  assign Full           = w_full;
  assign Count          = r_count;
  assign Valid          = w_valid;
  assign instructionOut = w_valid ? w_head : '0;

endmodule

// File: tb/tb_ir_queue.sv
module tb_ir_queue;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Ld;
  logic [DW-1:0] instruction;
  logic          LdReady;
  logic          Rd;
  logic          Flush;
  logic [DW-1:0] instructionOut;
  logic          Valid;
  logic          Full;
  logic [2:0]    Count;

  int n_checks = 0;
  int n_errors = 0;

  ir_queue #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Ld             (Ld),
    .instruction    (instruction),
    .LdReady        (LdReady),
    .Rd             (Rd),
    .Flush          (Flush),
    .instructionOut (instructionOut),
    .Valid          (Valid),
    .Full           (Full),
    .Count          (Count)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare every output against an expected queue state
  task automatic check_all(input string tag, input logic ev, input logic [DW-1:0] eo,
                           input int ec);
    check({tag, " Valid"}, int'(Valid), int'(ev));
    check({tag, " instructionOut"}, int'(instructionOut), int'(eo));
    check({tag, " Count"}, int'(Count), ec);
    check({tag, " Full"}, int'(Full), int'(ec == DEPTH));
    check({tag, " LdReady"}, int'(LdReady), int'(ec != DEPTH));
  endtask

  // One cycle: inputs applied over one edge, then released and the
  // registered state checked after the edge
  task automatic step(input logic rst, input logic ld, input logic rd, input logic fl,
                      input logic [DW-1:0] ins);
    @(negedge Clock);
    Reset = rst; Ld = ld; Rd = rd; Flush = fl; instruction = ins;
    @(posedge Clock);
    #1;
    Reset = 1'b0; Ld = 1'b0; Rd = 1'b0; Flush = 1'b0; instruction = '0;
    #1;
  endtask

  typedef struct {
    logic          rst;
    logic          ld;
    logic          rd;
    logic          fl;
    logic [DW-1:0] ins;
    logic          ev;
    logic [DW-1:0] eo;
    int            ec;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic ld, input logic rd, input logic fl,
                              input logic [DW-1:0] ins, input logic ev,
                              input logic [DW-1:0] eo, input int ec);
    vec_t v;
    v.rst = rst; v.ld = ld; v.rd = rd; v.fl = fl; v.ins = ins;
    v.ev = ev; v.eo = eo; v.ec = ec;
    return v;
  endfunction

  vec_t vecs [22];

  // Reference model state for the random phase
  logic [DW-1:0] model_q [$];

  initial begin
    Reset = 1'b1; Ld = 1'b0; Rd = 1'b0; Flush = 1'b0; instruction = '0;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    check_all("reset", 1'b0, 16'h0000, 0);

    //               rst  ld   rd   fl   ins       ev   eo        cnt
    vecs[0]  = mk(1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000, 0);
    vecs[1]  = mk(1'b0,1'b1,1'b0,1'b0,16'h1234, 1'b1,16'h1234, 1);
    vecs[2]  = mk(1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h1234, 1);
    vecs[3]  = mk(1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h1234, 1);
    vecs[4]  = mk(1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h1234, 1);
    vecs[5]  = mk(1'b0,1'b0,1'b1,1'b0,16'h0000, 1'b0,16'h0000, 0);
    vecs[6]  = mk(1'b0,1'b1,1'b0,1'b0,16'h0001, 1'b1,16'h0001, 1);
    vecs[7]  = mk(1'b0,1'b1,1'b0,1'b0,16'h0002, 1'b1,16'h0001, 2);
    vecs[8]  = mk(1'b0,1'b1,1'b0,1'b0,16'h0003, 1'b1,16'h0001, 3);
    vecs[9]  = mk(1'b0,1'b1,1'b0,1'b0,16'h0004, 1'b1,16'h0001, 4);
    vecs[10] = mk(1'b0,1'b1,1'b0,1'b0,16'h0005, 1'b1,16'h0001, 4);
    vecs[11] = mk(1'b0,1'b1,1'b1,1'b0,16'h0006, 1'b1,16'h0002, 3);
    vecs[12] = mk(1'b0,1'b0,1'b1,1'b0,16'h0000, 1'b1,16'h0003, 2);
    vecs[13] = mk(1'b0,1'b1,1'b1,1'b1,16'hABCD, 1'b0,16'h0000, 0);
    vecs[14] = mk(1'b0,1'b1,1'b0,1'b0,16'h0007, 1'b1,16'h0007, 1);
    vecs[15] = mk(1'b0,1'b1,1'b1,1'b0,16'h0008, 1'b1,16'h0008, 1);
    vecs[16] = mk(1'b0,1'b0,1'b1,1'b0,16'h0000, 1'b0,16'h0000, 0);
    vecs[17] = mk(1'b0,1'b0,1'b1,1'b0,16'h0000, 1'b0,16'h0000, 0);
    vecs[18] = mk(1'b0,1'b1,1'b0,1'b0,16'h1111, 1'b1,16'h1111, 1);
    vecs[19] = mk(1'b0,1'b1,1'b0,1'b0,16'h2222, 1'b1,16'h1111, 2);
    vecs[20] = mk(1'b1,1'b1,1'b1,1'b0,16'h3333, 1'b0,16'h0000, 0);
    vecs[21] = mk(1'b0,1'b1,1'b0,1'b0,16'h4444, 1'b1,16'h4444, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ld, vecs[i].rd, vecs[i].fl, vecs[i].ins);
      check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eo, vecs[i].ec);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    check_all("drain", 1'b0, 16'h0000, 0);

    // Nine push/pop pairs walk the pointers around the ring more than twice
    for (int i = 0; i < 9; i++) begin
      logic [DW-1:0] w;
      w = 16'hC000 + DW'(i);
      step(1'b0, 1'b1, 1'b0, 1'b0, w);
      check_all($sformatf("wrap_push%0d", i), 1'b1, w, 1);
      step(1'b0, 1'b0, 1'b1, 1'b0, '0);
      check_all($sformatf("wrap_pop%0d", i), 1'b0, 16'h0000, 0);
    end

    // Same-cycle view of a load into an empty queue
    @(negedge Clock);
    Ld = 1'b1; instruction = 16'h5A5A;
    #1;
`ifdef IR_QUEUE_BYPASS_EN
    check("bypass Valid", int'(Valid), 1);
    check("bypass instructionOut", int'(instructionOut), 16'h5A5A);
    Rd = 1'b1;
    #1;
    @(posedge Clock);
    #1;
    Ld = 1'b0; Rd = 1'b0;
    #1;
    check_all("bypass consumed", 1'b0, 16'h0000, 0);
`else
    check("no_bypass Valid", int'(Valid), 0);
    check("no_bypass instructionOut", int'(instructionOut), 16'h0000);
    @(posedge Clock);
    #1;
    Ld = 1'b0;
    #1;
    check_all("no_bypass stored", 1'b1, 16'h5A5A, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
`endif

    // Random traffic against a queue model
    model_q.delete();
    for (int n = 0; n < 3000; n++) begin
      logic r_rst, r_ld, r_rd, r_fl;
      logic [DW-1:0] r_ins;
      logic ev;
      logic [DW-1:0] eo;
      bit do_push, do_pop;
      r_rst = ($urandom_range(99) < 1);
      r_fl  = ($urandom_range(99) < 4);
      r_ld  = ($urandom_range(99) < 60);
      r_rd  = ($urandom_range(99) < 50);
      r_ins = DW'($urandom);

      ev = (model_q.size() != 0);
      eo = ev ? model_q[0] : '0;
`ifdef IR_QUEUE_BYPASS_EN
      if (model_q.size() == 0 && r_ld && !r_fl) begin
        ev = 1'b1;
        eo = r_ins;
      end
`endif
      @(negedge Clock);
      Reset = r_rst; Ld = r_ld; Rd = r_rd; Flush = r_fl; instruction = r_ins;
      #1;
      check_all($sformatf("rand%0d", n), ev, eo, model_q.size());
      @(posedge Clock);

      do_push = r_ld && (model_q.size() < DEPTH);
      do_pop  = r_rd && ev;
      if (r_rst || r_fl) begin
        model_q.delete();
      end else begin
        if (do_pop && model_q.size() != 0) begin
          void'(model_q.pop_front());
          if (do_push) model_q.push_back(r_ins);
        end else if (do_push && !do_pop) begin
          model_q.push_back(r_ins);
        end
      end
      #1;
    end
    Reset = 1'b0; Ld = 1'b0; Rd = 1'b0; Flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
